// File: rtl/cpu_seq_pkg.sv
// Shared types and encodings for the accumulator-datapath control sequencer.
package cpu_seq_pkg;

    localparam int unsigned INSTR_W   = 8;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned IMM_W     = 4;
    localparam int unsigned ALU_W     = 4;
    localparam int unsigned SEL_ACC_W = 2;
    localparam int unsigned STATE_W   = 3;

    // Enum values double as the cycle_status encoding.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4,
        S_ERROR  = 3'd5
    } seq_state_e;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h5;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h6;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h7;
    localparam logic [OPC_W-1:0] OP_STA = 4'h8;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h9;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JR  = 4'hB;
    localparam logic [OPC_W-1:0] OP_SHL = 4'hC;
    localparam logic [OPC_W-1:0] OP_SHR = 4'hD;
    localparam logic [OPC_W-1:0] OP_ILL = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'h1;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'h2;
    localparam logic [ALU_W-1:0] ALU_AND = 4'h3;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'h4;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'h5;
    localparam logic [ALU_W-1:0] ALU_SHL = 4'hC;
    localparam logic [ALU_W-1:0] ALU_SHR = 4'hD;

    localparam logic [SEL_ACC_W-1:0] SEL_ACC_ALU = 2'd0;
    localparam logic [SEL_ACC_W-1:0] SEL_ACC_IMM = 2'd1;
    localparam logic [SEL_ACC_W-1:0] SEL_ACC_REG = 2'd2;

    localparam logic SEL_PC_IMM = 1'b0;
    localparam logic SEL_PC_REG = 1'b1;

    typedef struct packed {
        logic                 inc_pc;
        logic                 load_pc;
        logic                 sel_pc;
        logic                 load_acc;
        logic [SEL_ACC_W-1:0] sel_acc;
        logic                 load_reg;
        logic [ALU_W-1:0]     alu_ctrl;
        logic                 halt_req;
    } seq_strb_t;

    // Non-ALU opcodes pass straight through so ALUCtrl always mirrors ir[7:4].
    function automatic logic [ALU_W-1:0] alu_ctrl_of(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            default: return ALU_W'(opc);
        endcase
    endfunction

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational (state, opcode, acc_zero) -> datapath strobe mapping.
// Opcode E behaviour depends on SEQ_ILLEGAL_TRAP_EN.
module seq_decode
    import cpu_seq_pkg::*;
(
    input  seq_state_e       state,
    input  logic [OPC_W-1:0] opc,
    input  logic             acc_zero,
    output seq_strb_t        strb
);

    always_comb begin
        strb          = '0;
        strb.alu_ctrl = alu_ctrl_of(opc);
        strb.sel_acc  = (opc == OP_LDI) ? SEL_ACC_IMM :
                        (opc == OP_LDA) ? SEL_ACC_REG : SEL_ACC_ALU;
        strb.sel_pc   = (opc == OP_JR) ? SEL_PC_REG : SEL_PC_IMM;

        // Load/PC strobes exist only in the single EXEC cycle.
        if (state == S_EXEC) begin
            case (opc)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
                OP_LDI, OP_LDA: begin
                    strb.load_acc = 1'b1;
                    strb.inc_pc   = 1'b1;
                end
                OP_STA: begin
                    strb.load_reg = 1'b1;
                    strb.inc_pc   = 1'b1;
                end
                OP_JMP, OP_JR: strb.load_pc = 1'b1;
                OP_JZ: begin
                    strb.load_pc = acc_zero;
                    strb.inc_pc  = !acc_zero;
                end
`ifdef SEQ_ILLEGAL_TRAP_EN
                OP_ILL: strb.halt_req = 1'b1;
`else
                OP_ILL: strb.inc_pc = 1'b1;
`endif
                OP_HLT: begin
                    strb.inc_pc   = 1'b1;
                    strb.halt_req = 1'b1;
                end
                default: strb.inc_pc = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer with run/halt control and fetch watchdog.
// Optional SEQ_ILLEGAL_TRAP_EN traps opcode E into HALT and raises illegal_op.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned TO_W          = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 acc_zero,
    output logic                 IncPC,
    output logic                 LoadPC,
    output logic                 SelPC,
    output logic                 LoadAcc,
    output logic [SEL_ACC_W-1:0] SelAcc,
    output logic                 LoadReg,
    output logic [ALU_W-1:0]     ALUCtrl,
    output logic [IMM_W-1:0]     RegAddr,
    output logic [IMM_W-1:0]     imm,
    output logic [STATE_W-1:0]   cycle_status,
    output logic                 halted,
    output logic                 fetch_err
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_op
`endif
);

    seq_state_e           state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [TO_W-1:0]      wd_q, wd_d;
    seq_strb_t            strb;

    seq_decode u_decode (
        .state    (state_q),
        .opc      (ir_q[INSTR_W-1:IMM_W]),
        .acc_zero (acc_zero),
        .strb     (strb)
    );

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // Set by a trapped opcode E, cleared when run resumes from HALT.
    always_comb begin
        illegal_d = illegal_q;
        if (state_q == S_EXEC && ir_q[INSTR_W-1:IMM_W] == OP_ILL) begin
            illegal_d = 1'b1;
        end else if (state_q == S_HALT && run) begin
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) illegal_q <= 1'b0;
        else      illegal_q <= illegal_d;
    end

    assign illegal_op = illegal_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wd_q    <= wd_d;
        end
    end

    // Watchdog only runs while FETCH is waiting; it rests at zero elsewhere.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wd_d    = '0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                    if (FETCH_TIMEOUT != 0 && wd_d == TO_W'(FETCH_TIMEOUT)) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = strb.halt_req ? S_HALT : S_FETCH;
            S_HALT:   if (run) state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
    end

    assign imem_req     = (state_q == S_FETCH);
    assign halted       = (state_q == S_HALT);
    assign fetch_err    = (state_q == S_ERROR);
    assign cycle_status = state_q;

    assign IncPC   = strb.inc_pc;
    assign LoadPC  = strb.load_pc;
    assign SelPC   = strb.sel_pc;
    assign LoadAcc = strb.load_acc;
    assign SelAcc  = strb.sel_acc;
    assign LoadReg = strb.load_reg;
    assign ALUCtrl = strb.alu_ctrl;
    assign RegAddr = ir_q[IMM_W-1:0];
    assign imm     = ir_q[IMM_W-1:0];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; define SEQ_ILLEGAL_TRAP_EN to cover the trap build.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic       imem_req;
    logic       imem_ready;
    logic [7:0] instr;
    logic       acc_zero;
    logic       IncPC;
    logic       LoadPC;
    logic       SelPC;
    logic       LoadAcc;
    logic [1:0] SelAcc;
    logic       LoadReg;
    logic [3:0] ALUCtrl;
    logic [3:0] RegAddr;
    logic [3:0] imm;
    logic [2:0] cycle_status;
    logic       halted;
    logic       fetch_err;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cnt;

    // {IncPC, LoadPC, LoadAcc, LoadReg}
    logic [3:0] strb_v;
    assign strb_v = {IncPC, LoadPC, LoadAcc, LoadReg};

    cpu_sequencer #(.FETCH_TIMEOUT(16), .TO_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .instr        (instr),
        .acc_zero     (acc_zero),
        .IncPC        (IncPC),
        .LoadPC       (LoadPC),
        .SelPC        (SelPC),
        .LoadAcc      (LoadAcc),
        .SelAcc       (SelAcc),
        .LoadReg      (LoadReg),
        .ALUCtrl      (ALUCtrl),
        .RegAddr      (RegAddr),
        .imm          (imm),
        .cycle_status (cycle_status),
        .halted       (halted),
        .fetch_err    (fetch_err)
`ifdef SEQ_ILLEGAL_TRAP_EN
        ,
        .illegal_op   (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while in FETCH; returns observing the EXEC cycle.
    task automatic do_fetch(input logic [7:0] op);
        imem_ready = 1'b1;
        instr      = op;
        tick();
        imem_ready = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; imem_ready = 1'b0; instr = 8'h00; acc_zero = 1'b0;
        repeat (3) tick();
        check("rst_status", 8'(cycle_status), 8'd0);
        check("rst_strb",   8'(strb_v), 8'h0);
        check("rst_flags",  8'({imem_req, halted, fetch_err}), 8'h0);

        // LDI 5, ready immediately
        rst = 1'b1; run = 1'b1; imem_ready = 1'b1; instr = 8'h65;
        tick();
        check("ldi_fetch", 8'({cycle_status, imem_req}), 8'h3);
        tick();
        imem_ready = 1'b0;
        check("ldi_decode", 8'(cycle_status), 8'd2);
        check("ldi_dec_strb", 8'({strb_v, imem_req}), 8'h0);
        check("ldi_dec_selacc", 8'(SelAcc), 8'd1);
        tick();
        check("ldi_exec", 8'(cycle_status), 8'd3);
        check("ldi_strb", 8'(strb_v), 8'b1010);
        check("ldi_selacc_imm", 8'({SelAcc, imm}), 8'h15);
        tick();
        check("ldi_back_fetch", 8'(cycle_status), 8'd1);

        // ADD r3 with ready delayed 4 cycles
        instr = 8'h13; cnt = 0;
        for (int i = 0; i < 5; i++) begin
            imem_ready = (i == 4);
            if (imem_req) cnt++;
            tick();
        end
        imem_ready = 1'b0;
        check("add_req_cycles", 8'(cnt), 8'd5);
        check("add_decode_noreq", 8'({cycle_status, imem_req}), 8'h4);
        tick();
        check("add_strb", 8'(strb_v), 8'b1010);
        check("add_alu_reg", 8'({ALUCtrl, RegAddr}), 8'h13);
        check("add_selacc_err", 8'({SelAcc, fetch_err}), 8'h0);
        tick();

        // JZ 7, taken then not taken
        acc_zero = 1'b1;
        do_fetch(8'hA7);
        check("jz_taken_strb", 8'(strb_v), 8'b0100);
        check("jz_taken_selpc", 8'(SelPC), 8'd0);
        tick();
        acc_zero = 1'b0;
        do_fetch(8'hA7);
        check("jz_not_strb", 8'(strb_v), 8'b1000);
        tick();

        // STA r2 and JR r4
        do_fetch(8'h82);
        check("sta_strb", 8'(strb_v), 8'b1001);
        tick();
        do_fetch(8'hB4);
        check("jr_strb", 8'({strb_v, SelPC}), 8'b01001);
        tick();

        // HLT, then hold 10 cycles with run low
        do_fetch(8'hF0);
        check("hlt_strb", 8'(strb_v), 8'b1000);
        run = 1'b0; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (halted && cycle_status == 3'd4) cnt++;
        end
        check("halt_cycles", 8'(cnt), 8'd10);
        run = 1'b1;
        tick();
        check("halt_resume", 8'({cycle_status, halted}), 8'h2);

        // Opcode E
        do_fetch(8'hE0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        check("ill_strb", 8'(strb_v), 8'b0000);
        run = 1'b0;
        tick();
        check("ill_halt", 8'({halted, illegal_op, IncPC}), 8'b110);
        run = 1'b1;
        tick();
        check("ill_resume", 8'({cycle_status, illegal_op}), 8'h2);
`else
        check("ill_nop_strb", 8'(strb_v), 8'b1000);
        tick();
        check("ill_nop_fetch", 8'({cycle_status, halted}), 8'h2);
`endif

        // Watchdog: ready never arrives
        imem_ready = 1'b0; cnt = 0;
        for (int i = 0; i < 40 && !fetch_err; i++) begin
            if (imem_req) cnt++;
            tick();
        end
        check("wd_fetch_cycles", 8'(cnt), 8'd16);
        check("wd_error", 8'({cycle_status, fetch_err, imem_req}), 8'b10110);
        imem_ready = 1'b1; instr = 8'h65;
        tick();
        check("wd_late_ready", 8'({cycle_status, fetch_err}), 8'b1011);
        imem_ready = 1'b0;
        rst = 1'b0;
        tick();
        check("wd_reset", 8'({cycle_status, fetch_err, imem_req}), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 8-bit accumulator datapath: program counter, instruction memory, register file, accumulator and ALU. Fetches one instruction over a req/ready handshake, decodes opcode instr[7:4] and immediate instr[3:0], and drives every datapath strobe (PC, accumulator, register-file load, ALU op select) for one execute cycle. Also provides run/halt control and a fetch watchdog.

Parameters:
FETCH_TIMEOUT, 16, max cycles FETCH waits for imem_ready before entering ERROR; 0 disables the watchdog
TO_W, 5, watchdog counter width; must hold FETCH_TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
run  in  1  level; leave IDLE/HALT when high
imem_req  out  1  fetch request to instruction memory
imem_ready  in  1  instr valid this cycle
instr  in  8  instruction byte {opcode[3:0], imm[3:0]}
acc_zero  in  1  accumulator == 0 flag
IncPC  out  1  PC <= PC+1
LoadPC  out  1  PC load strobe
SelPC  out  1  PC source: 0 = imm, 1 = register data
LoadAcc  out  1  accumulator load strobe
SelAcc  out  2  acc source: 0 = ALU, 1 = imm, 2 = register data
LoadReg  out  1  register-file write strobe (data = acc)
ALUCtrl  out  4  ALU operation code
RegAddr  out  4  register-file address (= ir imm)
imm  out  4  latched immediate
cycle_status  out  3  current state encoding
halted  out  1  high in HALT
fetch_err  out  1  sticky; high in ERROR

Behaviour:
- Reset (rst low at clk edge): state IDLE, ir = 0, watchdog = 0. All strobes, imem_req, halted and fetch_err are 0. rst overrides any state, including mid-fetch and ERROR.
- States and cycle_status encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, HALT 4, ERROR 5.
- IDLE -> FETCH when run = 1.
- FETCH:
  - imem_req = 1.
  - If imem_ready = 1: ir <= instr, go to DECODE, clear watchdog.
  - Otherwise increment watchdog. When it equals FETCH_TIMEOUT (and FETCH_TIMEOUT != 0): go to ERROR.
- DECODE: one cycle, no strobes. ALUCtrl, SelAcc and SelPC settle from ir.
- EXEC: one cycle. Strobes are combinational from (state == EXEC, ir) and are high for exactly this cycle. Next state is FETCH, except HLT -> HALT.
- Minimum cost is 3 cycles per instruction, plus wait cycles.
- Opcode map (A = accumulator, R = reg[imm]):
  - 0 NOP: IncPC.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, C SHL, D SHR: A <= A op R. LoadAcc, SelAcc = 0, ALUCtrl = opcode, IncPC.
  - 6 LDI: A <= imm. LoadAcc, SelAcc = 1, IncPC.
  - 7 LDA: A <= R. LoadAcc, SelAcc = 2, IncPC.
  - 8 STA: R <= A. LoadReg, IncPC.
  - 9 JMP: LoadPC, SelPC = 0.
  - A JZ: if acc_zero then LoadPC, SelPC = 0; else IncPC. acc_zero is sampled in EXEC.
  - B JR: LoadPC, SelPC = 1.
  - E reserved: handled per Optional Feature.
  - F HLT: IncPC, then HALT.
- IncPC and LoadPC are never high together.
- Outside EXEC, ALUCtrl = ir[7:4] and all load strobes are 0.
- HALT: halted = 1. Move to FETCH on the first cycle run = 1. If run is held high, HALT lasts one cycle.
- ERROR: fetch_err = 1, imem_req = 0. Exit only via reset.
- A late imem_ready that arrives after ERROR is entered is ignored.

Optional Feature:
- Macro: SEQ_ILLEGAL_TRAP_EN.
- Defined: opcode E in EXEC asserts no strobes and moves to HALT with halted = 1. Additional output illegal_op (1 bit) is set and stays high until reset or the next run-resume. PC is not incremented, so the offending address is preserved.
- Undefined: opcode E executes as NOP (IncPC only), and there is no illegal_op port.

Decomposition:
- Package cpu_seq_pkg holds:
  - state enum and cycle_status encodings
  - opcode constants OP_NOP..OP_HLT
  - ALUCtrl codes
  - SelAcc and SelPC constants
- One natural sub-module, seq_decode: purely combinational mapping (state, ir, acc_zero) -> strobe bundle.
- The FSM, watchdog and ir register stay in cpu_sequencer.

Test Plan:
- Reset held 3 cycles, then run = 1 with instr 0x65 (LDI 5) ready immediately -> cycle_status 1, 2, 3. In EXEC: LoadAcc = 1, SelAcc = 1, imm = 5, IncPC = 1. Then back to FETCH.
- imem_ready delayed 4 cycles, instr 0x13 (ADD r3) -> imem_req high for 5 cycles. EXEC has LoadAcc = 1, ALUCtrl = 1, RegAddr = 3; no error.
- instr 0xA7 (JZ 7): with acc_zero = 1 -> LoadPC = 1, SelPC = 0, IncPC = 0. With acc_zero = 0 -> IncPC = 1, LoadPC = 0.
- instr 0xF0 (HLT) -> IncPC in EXEC, then halted = 1 with run = 0 for 10 cycles. On run = 1 -> FETCH on the next cycle.
- FETCH_TIMEOUT = 16, imem_ready held 0 -> fetch_err = 1 after 16 FETCH cycles, imem_req drops. A later rst low returns to IDLE with fetch_err = 0.
- instr 0xE0: with SEQ_ILLEGAL_TRAP_EN -> halted = 1, illegal_op = 1, IncPC never pulses. Without the macro -> IncPC only, then FETCH.
